// File: rtl/imm_gen_pipe.sv
// Immediate decoder for RV32/RV64 formats feeding a DEPTH-entry output buffer
// with valid/ready on both sides; flush drops everything buffered or arriving.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [31:0]              Instr,
   input  logic [2:0]               ImmSrc,
   input  logic                     valid_in,
   output logic                     ready_in,
   output logic [XLEN-1:0]          ImmOp,
   output logic                     ImmErr,
   output logic                     valid_out,
   input  logic                     ready_out,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]      imm32;
   logic             imm_err;
   logic [XLEN-1:0]  imm_ext;

   logic [XLEN-1:0]  mem   [DEPTH];
   logic             err_q [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             push;
   logic             pop;

   always_comb begin
      imm32   = '0;
      imm_err = 1'b0;
      case (ImmSrc)
         3'b000: imm32 = {{20{Instr[31]}}, Instr[31:20]};
         3'b001: imm32 = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
         3'b010: imm32 = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
         3'b011: imm32 = {Instr[31:12], 12'b0};
         3'b100: imm32 = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
         3'b101: imm32 = {27'b0, Instr[19:15]};
         3'b110: imm_err = 1'b1;
         default: imm32 = Instr;
      endcase
   end

   // Every format is already sign-correct at 32 bits, so widening to XLEN just replicates bit 31.
   always_comb begin
      imm_ext       = {XLEN{imm32[31]}};
      imm_ext[31:0] = imm32;
   end

   assign ready_in  = (count_q != CW'(DEPTH));
   assign valid_out = (count_q != '0);
   assign push      = valid_in & ready_in & ~flush;
   assign pop       = valid_out & ready_out & ~flush;
   assign ImmOp     = mem[rd_ptr];
   assign ImmErr    = err_q[rd_ptr];
   assign count     = count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i]   <= '0;
            err_q[i] <= 1'b0;
         end
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr]   <= imm_ext;
            err_q[wr_ptr] <= imm_err;
            wr_ptr        <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: 32-bit and 64-bit instances, directed vectors
// with hand-computed immediates, stall/flush/reset scenarios.
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   logic        rst = 1'b1;
   logic        a_flush = 1'b0;
   logic [31:0] a_instr = '0;
   logic [2:0]  a_src = '0;
   logic        a_valid_in = 1'b0;
   logic        a_ready_in;
   logic [31:0] a_imm;
   logic        a_err;
   logic        a_valid_out;
   logic        a_ready_out = 1'b1;
   logic [1:0]  a_count;

   logic        b_flush = 1'b0;
   logic [31:0] b_instr = '0;
   logic [2:0]  b_src = '0;
   logic        b_valid_in = 1'b0;
   logic        b_ready_in;
   logic [63:0] b_imm;
   logic        b_err;
   logic        b_valid_out;
   logic        b_ready_out = 1'b1;
   logic [1:0]  b_count;

   imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
      .clk(clk), .rst(rst), .flush(a_flush), .Instr(a_instr), .ImmSrc(a_src),
      .valid_in(a_valid_in), .ready_in(a_ready_in), .ImmOp(a_imm), .ImmErr(a_err),
      .valid_out(a_valid_out), .ready_out(a_ready_out), .count(a_count)
   );

   imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
      .clk(clk), .rst(rst), .flush(b_flush), .Instr(b_instr), .ImmSrc(b_src),
      .valid_in(b_valid_in), .ready_in(b_ready_in), .ImmOp(b_imm), .ImmErr(b_err),
      .valid_out(b_valid_out), .ready_out(b_ready_out), .count(b_count)
   );

   typedef struct {
      logic [63:0] imm;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        q32[$];
   logic [63:0] q64[$];
   exp_t        e32;
   logic [63:0] e64;
   int          passes = 0;
   int          total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (!rst && !a_flush && a_valid_out && a_ready_out) begin
         if (q32.size() == 0) begin
            chk("unexpected_out32", 64'(a_imm), 64'hDEAD);
         end else begin
            e32 = q32.pop_front();
            chk("imm32", 64'(a_imm), e32.imm);
            chk("err32", 64'(a_err), 64'(e32.err));
            if (e32.cyc >= 0) chk("latency32", 64'(cyc), 64'(e32.cyc));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && !b_flush && b_valid_out && b_ready_out) begin
         if (q64.size() == 0) begin
            chk("unexpected_out64", b_imm, 64'hDEAD);
         end else begin
            e64 = q64.pop_front();
            chk("imm64", b_imm, e64);
            chk("err64", 64'(b_err), 64'd0);
         end
      end
   end

   task automatic send32(input logic [31:0] ins, input logic [2:0] src,
                         input logic [63:0] exp, input logic err, input bit timed);
      bit ok = 0;
      a_instr    = ins;
      a_src      = src;
      a_valid_in = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (a_ready_in) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("accept_timeout32", 64'd0, 64'd1);
      else q32.push_back('{exp, err, timed ? cyc + 1 : -1});
      @(posedge clk);
      #1;
   endtask

   task automatic send64(input logic [31:0] ins, input logic [2:0] src, input logic [63:0] exp);
      bit ok = 0;
      b_instr    = ins;
      b_src      = src;
      b_valid_in = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (b_ready_in) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("accept_timeout64", 64'd0, 64'd1);
      else q64.push_back(exp);
      @(posedge clk);
      #1;
   endtask

   task automatic drain;
      for (int i = 0; i < 40 && (q32.size() != 0 || q64.size() != 0); i++) @(negedge clk);
      chk("drain_q32", 64'(q32.size()), 64'd0);
      chk("drain_q64", 64'(q64.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_count", 64'(a_count), 64'd0);
      chk("rst_valid_out", 64'(a_valid_out), 64'd0);
      chk("rst_ready_in", 64'(a_ready_in), 64'd1);
      chk("rst_imm", 64'(a_imm), 64'd0);
      @(posedge clk);
      #1;

      // back-to-back stream, one result per cycle
      a_ready_out = 1'b1;
      send32(32'hFFF00093, 3'b000, 64'hFFFFFFFF, 1'b0, 1);
      send32(32'hFE20AE23, 3'b001, 64'hFFFFFFFC, 1'b0, 1);
      send32(32'hFE000CE3, 3'b010, 64'hFFFFFFF8, 1'b0, 1);
      send32(32'h123450B7, 3'b011, 64'h12345000, 1'b0, 1);
      send32(32'hFFDFF0EF, 3'b100, 64'hFFFFFFFC, 1'b0, 1);
      send32(32'h800F8073, 3'b101, 64'h0000001F, 1'b0, 0);
      send32(32'h80000001, 3'b111, 64'h80000001, 1'b0, 0);
      send32(32'hFFFFFFFF, 3'b110, 64'h0,        1'b1, 0);
      send32(32'h00500093, 3'b000, 64'h5,        1'b0, 0);
      a_valid_in = 1'b0;
      drain();

      send64(32'hFFF00093, 3'b000, 64'hFFFFFFFFFFFFFFFF);
      send64(32'h800F8073, 3'b101, 64'h000000000000001F);
      send64(32'h800000B7, 3'b011, 64'hFFFFFFFF80000000);
      send64(32'hFFDFF0EF, 3'b100, 64'hFFFFFFFFFFFFFFFC);
      send64(32'h80000000, 3'b111, 64'hFFFFFFFF80000000);
      b_valid_in = 1'b0;
      drain();

      // stall with a full buffer, then release
      a_ready_out = 1'b0;
      send32(32'h00100093, 3'b000, 64'h1, 1'b0, 0);
      send32(32'h00200093, 3'b000, 64'h2, 1'b0, 0);
      a_instr    = 32'h00300093;
      a_src      = 3'b000;
      a_valid_in = 1'b1;
      @(negedge clk);
      chk("full_ready_in", 64'(a_ready_in), 64'd0);
      chk("full_count", 64'(a_count), 64'd2);
      chk("stall_imm", 64'(a_imm), 64'd1);
      chk("stall_valid", 64'(a_valid_out), 64'd1);
      @(negedge clk);
      chk("stall_hold_imm", 64'(a_imm), 64'd1);
      chk("stall_hold_count", 64'(a_count), 64'd2);
      @(posedge clk);
      #1 a_ready_out = 1'b1;
      send32(32'h00300093, 3'b000, 64'h3, 1'b0, 0);
      a_valid_in = 1'b0;
      drain();

      // flush with input and pop in the same cycle
      a_ready_out = 1'b0;
      send32(32'h00800093, 3'b000, 64'h8, 1'b0, 0);
      send32(32'h00900093, 3'b000, 64'h9, 1'b0, 0);
      a_valid_in = 1'b0;
      a_flush    = 1'b1;
      a_valid_in = 1'b1;
      a_instr    = 32'h00700093;
      a_ready_out = 1'b1;
      @(posedge clk);
      #1;
      a_flush    = 1'b0;
      a_valid_in = 1'b0;
      q32.delete();
      @(negedge clk);
      chk("flush_count", 64'(a_count), 64'd0);
      chk("flush_valid_out", 64'(a_valid_out), 64'd0);
      chk("flush_ready_in", 64'(a_ready_in), 64'd1);
      repeat (3) begin
         @(negedge clk);
         chk("flush_no_ghost", 64'(a_valid_out), 64'd0);
      end
      @(posedge clk);
      #1;

      // reset while full
      a_ready_out = 1'b0;
      send32(32'hFFFFFFFF, 3'b110, 64'h0, 1'b1, 0);
      send32(32'h00A00093, 3'b000, 64'hA, 1'b0, 0);
      a_valid_in = 1'b0;
      @(negedge clk);
      chk("prerst_err", 64'(a_err), 64'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      q32.delete();
      @(negedge clk);
      chk("rst2_count", 64'(a_count), 64'd0);
      chk("rst2_valid_out", 64'(a_valid_out), 64'd0);
      chk("rst2_ready_in", 64'(a_ready_in), 64'd1);
      chk("rst2_imm", 64'(a_imm), 64'd0);
      chk("rst2_err", 64'(a_err), 64'd0);
      @(posedge clk);
      #1 a_ready_out = 1'b1;

      send32(32'h00B00093, 3'b000, 64'hB, 1'b0, 0);
      a_valid_in = 1'b0;
      drain();

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
